// File: rtl/sseg_scan.sv
// Six-slot time-multiplexing scan controller for the clock display.
// It adds a blanked guard interval to each slot, per-slot blink and an invalid-BCD guard.
module sseg_scan #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 83
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [29:0] digits_in,
    input  logic [5:0]  blink_mask,
    output logic [4:0]  digit,
    output logic [2:0]  digit_pos,
    output logic        blank,
    output logic        frame_tick
);

    localparam int TW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    pos_q, pos_d;
    logic [29:0]   snap_digits_q, snap_digits_d;
    logic [5:0]    snap_mask_q, snap_mask_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [4:0]    digit_q, digit_d;
    logic          blank_q, blank_d;
    logic          frame_tick_q, frame_tick_d;
    logic [4:0]    slot_code;
    logic          bad_bcd;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        pos_d         = pos_q;
        snap_digits_d = snap_digits_q;
        snap_mask_d   = snap_mask_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_tick_d  = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            timer_d = '0;
            pos_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = GUARD;
                    timer_d       = '0;
                    pos_d         = 3'd0;
                    snap_digits_d = digits_in;
                    snap_mask_d   = blink_mask;
                end
                GUARD: begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q == TW'(BLANK_CYCLES - 1)) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (timer_q == TW'(DIGIT_CYCLES - 1)) begin
                        timer_d = '0;
                        state_d = GUARD;
                        if (pos_q == 3'd5) begin
                            // Frame boundary: the only point where new input data is taken.
                            pos_d         = 3'd0;
                            frame_tick_d  = 1'b1;
                            snap_digits_d = digits_in;
                            snap_mask_d   = blink_mask;
                            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                                frame_cnt_d   = '0;
                                blink_phase_d = ~blink_phase_q;
                            end else begin
                                frame_cnt_d = frame_cnt_q + 1'b1;
                            end
                        end else begin
                            pos_d = pos_q + 3'd1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    pos_d   = 3'd0;
                end
            endcase
        end
    end

    // Outputs are derived from next-state values so the registered pins line up with the state.
    always_comb begin
        slot_code = snap_digits_d[int'(pos_d) * 5 +: 5];
        bad_bcd   = (slot_code[3:0] > 4'd9);
        digit_d   = (state_d == IDLE || bad_bcd) ? 5'd0 : slot_code;
        blank_d   = (state_d != SHOW) || bad_bcd || (blink_phase_d && snap_mask_d[pos_d]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            pos_q         <= 3'd0;
            snap_digits_q <= '0;
            snap_mask_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            digit_q       <= 5'd0;
            blank_q       <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pos_q         <= pos_d;
            snap_digits_q <= snap_digits_d;
            snap_mask_q   <= snap_mask_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            digit_q       <= digit_d;
            blank_q       <= blank_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign digit      = digit_q;
    assign digit_pos  = pos_q;
    assign blank      = blank_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan: a frame-position model pushes the expected outputs for every clock,
// and those values are popped and compared just after the edge.
module tb_sseg_scan;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FRAME = 6 * DC;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [29:0] digits_in;
    logic [5:0]  blink_mask;
    logic [4:0]  digit;
    logic [2:0]  digit_pos;
    logic        blank;
    logic        frame_tick;

    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Model state: cycles into the current frame and frames completed since reset.
    logic        m_run = 1'b0;
    int          m_t = 0;
    int          m_frames = 0;
    logic [29:0] m_snap = '0;
    logic [5:0]  m_msk = '0;

    sseg_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .digits_in  (digits_in),
        .blink_mask (blink_mask),
        .digit      (digit),
        .digit_pos  (digit_pos),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_push();
        logic [9:0] e;
        logic [4:0] code;
        logic       tk;
        logic       bad;
        logic       phase;
        logic       bl;
        int         slot;
        int         in_slot;
        tk = 1'b0;
        if (!enable) begin
            m_run = 1'b0;
            e = {1'b0, 1'b1, 3'd0, 5'd0};
        end else begin
            if (!m_run) begin
                m_run  = 1'b1;
                m_t    = 0;
                m_snap = digits_in;
                m_msk  = blink_mask;
            end else begin
                m_t++;
                if (m_t == FRAME) begin
                    m_t = 0;
                    tk  = 1'b1;
                    m_frames++;
                    m_snap = digits_in;
                    m_msk  = blink_mask;
                end
            end
            slot    = m_t / DC;
            in_slot = m_t % DC;
            code    = m_snap[slot * 5 +: 5];
            bad     = (code[3:0] > 4'd9);
            phase   = ((m_frames / BF) % 2) == 1;
            bl      = (in_slot < BC) || bad || (phase && m_msk[slot]);
            e = {tk, bl, 3'(slot), bad ? 5'd0 : code};
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        logic [9:0] e;
        model_push();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("frame_tick", 32'(frame_tick), 32'(e[9]));
            check_eq("blank", 32'(blank), 32'(e[8]));
            check_eq("digit_pos", 32'(digit_pos), 32'(e[7:5]));
            check_eq("digit", 32'(digit), 32'(e[4:0]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_digit"}, 32'(digit), 32'd0);
        check_eq({tag, "_pos"}, 32'(digit_pos), 32'd0);
        check_eq({tag, "_blank"}, 32'(blank), 32'd1);
        check_eq({tag, "_tick"}, 32'(frame_tick), 32'd0);
    endtask

    initial begin
        int slot;
        rst        = 1'b1;
        enable     = 1'b0;
        digits_in  = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        blink_mask = 6'b000011;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b1;

        // Six frames: mid-frame edit of slot 1, blink of slots 0/1, invalid BCD and dp passthrough.
        for (int n = 0; n < 6 * FRAME; n++) begin
            if (n == FRAME + 3 * DC) digits_in[9:5] = 5'd7;
            if (n == 2 * FRAME + 4) begin
                digits_in[24:20] = 5'b1_1100;
                digits_in[14:10] = 5'b1_0110;
            end
            step();
        end

        // Random code edits, taken only at frame boundaries.
        for (int n = 0; n < 2 * FRAME; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                slot = $urandom_range(0, 5);
                digits_in[slot * 5 +: 5] = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 63) == 0) blink_mask = 6'($urandom_range(0, 63));
            step();
        end

        // Drop enable in slot 3 SHOW, then restart.
        for (int i = 0; i < 2 * FRAME && m_t != 3 * DC + 3; i++) step();
        check_eq("reach_slot3_show", 32'(m_t), 32'(3 * DC + 3));
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        for (int n = 0; n < FRAME + 12; n++) step();

        // Asynchronous reset in the middle of a SHOW interval.
        for (int i = 0; i < 2 * DC && (m_t % DC) != 5; i++) step();
        check_eq("reach_show", 32'(m_t % DC), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        m_run    = 1'b0;
        m_t      = 0;
        m_frames = 0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst = 1'b0;
        for (int n = 0; n < 3 * DC; n++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
